// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and parity modes.
// Imported by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 1250;  // 12 MHz / 9600 baud
  localparam int unsigned DATA_BITS            = 8;

  localparam int unsigned PARITY_MODE_EVEN = 0;
  localparam int unsigned PARITY_MODE_ODD  = 1;

  function automatic int unsigned frame_bits(input int unsigned parity_en,
                                             input int unsigned stop_bits);
    return 1 + DATA_BITS + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level valid/ready handshake between a requester and the UART transmitter.
interface uart_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, pulses bit_tick on the final count.
// restart holds the counter at zero so the first period starts cleanly.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter  int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  localparam int unsigned CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  output logic          bit_tick,
  output logic [CW-1:0] count
);

  assign bit_tick = (count == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || restart || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte over valid/ready and sends it LSB first with
// optional parity and one or two stop bits; tx and tx_done are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = PARITY_MODE_EVEN,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave tx_if,
  output logic     tx,
  output logic     tx_busy,
  output logic     tx_done
);

  localparam int unsigned CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic        ODD = (PARITY_ODD == PARITY_MODE_ODD);

  uart_state_t state, state_d;

  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic          par_q, par_d;
  logic          tx_d, done_d;
  logic          accept, bit_tick;
  logic          last_data, last_stop, pre_tick;
  logic [CW-1:0] baud_cnt;

  assign tx_if.tx_ready = (state == IDLE) && !rst;
  assign accept         = tx_if.tx_valid && tx_if.tx_ready;
  assign tx_busy        = (state != IDLE);
  assign last_data      = (bit_idx == 3'(DATA_BITS - 1));
  assign last_stop      = (bit_idx == 3'(STOP_BITS - 1));
  assign pre_tick       = (baud_cnt == CW'(CLKS_PER_BIT - 2));

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (state == IDLE),
    .bit_tick(bit_tick),
    .count   (baud_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_idx <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_d;
      shift_q <= shift_d;
      bit_idx <= bit_idx_d;
      par_q   <= par_d;
      tx      <= tx_d;
      tx_done <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = START;
      START:   if (bit_tick) state_d = DATA;
      DATA:    if (bit_tick && last_data) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_tick) state_d = STOP;
      STOP:    if (bit_tick && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; the bit index is reused to count stop bits.
  always_comb begin
    shift_d   = shift_q;
    bit_idx_d = bit_idx;
    par_d     = par_q;
    unique case (state)
      IDLE: begin
        bit_idx_d = '0;
        if (accept) begin
          shift_d = tx_if.tx_data;
          par_d   = (^tx_if.tx_data) ^ ODD;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_tick) bit_idx_d = last_stop ? 3'd0 : bit_idx + 3'd1;
      end
      default: ;
    endcase
  end

  // Outputs are derived from next-cycle values so the registers change on the same
  // edge as the state; tx_done is armed one clock before the final stop clock.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    done_d = (state == STOP) && pre_tick && last_stop;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four configurations (8N1, even parity, odd parity, 8N2)
// checked cycle by cycle against hand-written frame bit strings.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [3:0] valid;
  logic [7:0] data [4];
  logic [3:0] tx_w, busy_w, done_w, ready_w;

  int compared   = 0;
  int mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if if_a ();
  uart_tx_if if_e ();
  uart_tx_if if_o ();
  uart_tx_if if_s ();

  assign if_a.tx_valid = valid[0];
  assign if_a.tx_data  = data[0];
  assign ready_w[0]    = if_a.tx_ready;
  assign if_e.tx_valid = valid[1];
  assign if_e.tx_data  = data[1];
  assign ready_w[1]    = if_e.tx_ready;
  assign if_o.tx_valid = valid[2];
  assign if_o.tx_data  = data[2];
  assign ready_w[2]    = if_o.tx_ready;
  assign if_s.tx_valid = valid[3];
  assign if_s.tx_data  = data[3];
  assign ready_w[3]    = if_s.tx_ready;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_8n1 (
    .clk(clk), .rst(rst), .tx_if(if_a), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_even (
    .clk(clk), .rst(rst), .tx_if(if_e), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
    .clk(clk), .rst(rst), .tx_if(if_o), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_8n2 (
    .clk(clk), .rst(rst), .tx_if(if_s), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input int idx, input string tag, input logic rdy);
    chk($sformatf("%s[%0d].tx", tag, idx), tx_w[idx], 1'b1);
    chk($sformatf("%s[%0d].busy", tag, idx), busy_w[idx], 1'b0);
    chk($sformatf("%s[%0d].done", tag, idx), done_w[idx], 1'b0);
    chk($sformatf("%s[%0d].ready", tag, idx), ready_w[idx], rdy);
  endtask

  // Called in cycle 1 after accept; returns in the forced IDLE cycle after the frame.
  task automatic check_frame(input int idx, input string bits, input bit scramble);
    int n;
    n = bits.len();
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("frame[%0d].bit%0d.c%0d.tx", idx, i, c), tx_w[idx], (bits[i] == "1"));
        chk($sformatf("frame[%0d].bit%0d.c%0d.done", idx, i, c), done_w[idx],
            ((i == n - 1) && (c == CPB - 1)));
        chk($sformatf("frame[%0d].bit%0d.c%0d.busy", idx, i, c), busy_w[idx], 1'b1);
        chk($sformatf("frame[%0d].bit%0d.c%0d.ready", idx, i, c), ready_w[idx], 1'b0);
        if (scramble) begin
          valid[idx] = 1'($urandom_range(0, 1));
          data[idx]  = 8'($urandom);
        end
        @(negedge clk);
      end
    end
    if (scramble) valid[idx] = 1'b0;
    chk_idle(idx, "frame_end", 1'b1);
  endtask

  task automatic send_frame(input int idx, input logic [7:0] b, input string bits,
                            input bit hold, input bit scramble);
    valid[idx] = 1'b1;
    data[idx]  = b;
    chk($sformatf("send[%0d].ready", idx), ready_w[idx], 1'b1);
    @(negedge clk);
    if (!hold) valid[idx] = 1'b0;
    if (scramble) data[idx] = ~b;
    check_frame(idx, bits, scramble);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    valid = '0;
    for (int i = 0; i < 4; i++) data[i] = '0;

    // Reset held for three cycles, then released
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk_idle(i, "reset", 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk_idle(i, "post_reset", 1'b1);

    // 8N1, 0xA5
    send_frame(0, 8'hA5, "0101001011", 1'b0, 1'b0);

    // Parity on 0x07: even -> 1, odd -> 0
    send_frame(1, 8'h07, "01110000011", 1'b0, 1'b0);
    send_frame(2, 8'h07, "01110000001", 1'b0, 1'b0);

    // Back-to-back with valid held: 0x55 then 0xAA
    send_frame(0, 8'h55, "0101010101", 1'b1, 1'b0);
    send_frame(0, 8'hAA, "0010101011", 1'b0, 1'b0);

    // rst and valid together: no accept
    valid[0] = 1'b1;
    data[0]  = 8'hFF;
    rst      = 1'b1;
    @(negedge clk);
    chk_idle(0, "rst_valid", 1'b0);
    rst      = 1'b0;
    valid[0] = 1'b0;
    @(negedge clk);
    chk_idle(0, "rst_valid_after", 1'b1);

    // Mid-frame reset during data bit 3 of 0xA5 (bit 3 = 0)
    valid[0] = 1'b1;
    data[0]  = 8'hA5;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("mid.bit3.tx", tx_w[0], 1'b0);
    chk("mid.bit3.busy", busy_w[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle(0, "mid_rst", 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      chk($sformatf("after_rst.c%0d.done", k), done_w[0], 1'b0);
      chk($sformatf("after_rst.c%0d.tx", k), tx_w[0], 1'b1);
    end
    send_frame(0, 8'h3C, "0001111001", 1'b0, 1'b0);

    // Two stop bits, inputs toggling while busy: 0xC3
    send_frame(3, 8'hC3, "01100001111", 1'b0, 1'b1);
    @(negedge clk);
    chk_idle(3, "no_extra_accept", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; the transmit-side counterpart to the team's UART receiver.
- Takes a parallel byte over a valid/ready handshake and serialises it on the tx line.
- Frame format: LSB first, 8N1 by default, optional parity and a second stop bit.
- Generates bit timing internally from the system clock, so the same fabric clock drives tx and rx control logic.

Parameters:
- CLKS_PER_BIT, 1250, system clocks per bit period (12 MHz / 9600 baud); must be >= 2.
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, with PARITY_EN = 1: 0 = even parity, 1 = odd parity.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only on the accept cycle.
- tx_valid  input  1  requester has a byte on tx_data.
- tx_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line; idle-high.
- tx_busy  output  1  frame in progress (any state other than IDLE).
- tx_done  output  1  one-clock pulse when the final stop bit completes.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - tx = 1, tx_busy = 0, tx_done = 0, state = IDLE, counters = 0.
  - tx_ready = 0 while rst is high; tx_ready = 1 in the first cycle after rst deasserts.
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Handshake:
  - tx_ready = (state == IDLE) && !rst, combinational.
  - Accept occurs on a clock edge where tx_valid && tx_ready: tx_data is latched into the shift register.
  - tx_valid while busy has no effect; tx_data changes after accept do not affect the frame.
- States: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
  - IDLE: tx = 1.
  - START: tx = 0 for CLKS_PER_BIT clocks.
  - DATA: 8 bits, shift register bit 0 first, each held for exactly CLKS_PER_BIT clocks; a 3-bit bit counter advances at each bit boundary; after bit 7 go to PARITY or STOP.
  - PARITY: tx = XOR of the latched byte, inverted when PARITY_ODD = 1; held for CLKS_PER_BIT clocks.
  - STOP: tx = 1 for STOP_BITS * CLKS_PER_BIT clocks; on the last clock tx_done = 1 and the next state is IDLE.
- Timing:
  - tx changes at the clock edge that accepts the byte; it goes low in the cycle following accept.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - Minimum frame-to-frame spacing is frame_bits * CLKS_PER_BIT + 1 cycles, where frame_bits = 1 + 8 + PARITY_EN + STOP_BITS. The extra cycle is one forced IDLE cycle in which tx_ready = 1.
- Outputs: tx is registered (glitch-free). tx_done is registered and high for exactly one cycle.
- Bit counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
- Boundary cases:
  - rst mid-frame aborts the frame: tx returns to 1 at that edge, no tx_done pulse.
  - rst and tx_valid in the same cycle: no accept.
  - tx_valid held high continuously produces back-to-back frames separated by the single IDLE cycle.

Decomposition:
- Shared package uart_pkg:
  - state encoding (IDLE, START, DATA, PARITY, STOP);
  - default CLKS_PER_BIT;
  - parity-mode constants, reused by the receiver.
- One natural sub-module, uart_baud_gen:
  - bit-period counter with a restart input and a one-cycle bit_tick output;
  - reusable later for receiver oversampling.

Test Plan (CLKS_PER_BIT = 4 unless stated):
- Reset: hold rst for 3 cycles -> tx = 1, tx_busy = 0, tx_done = 0, tx_ready = 0 during reset and 1 the cycle after release.
- Single byte, 8N1: send 0xA5 -> tx emits 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles; tx_done pulses once, in cycle 40 after accept; tx_ready returns 1 the next cycle.
- Parity: PARITY_EN = 1 with byte 0x07 -> parity bit 1 when even, 0 when odd; frame is 11 bits / 44 cycles.
- Back-to-back: tx_valid held high with 0x55 then 0xAA -> second start bit begins exactly 2 cycles after the first tx_done pulse (the IDLE accept cycle plus the transition edge); both bytes correct.
- Mid-frame reset: assert rst during data bit 3 -> tx = 1 at that edge, no tx_done; a new byte 0x3C afterwards transmits correctly.
- STOP_BITS = 2 with tx_valid/tx_data toggling while busy -> stop high for 8 cycles, in-flight frame unchanged, no extra accept until IDLE.
